// File: rtl/mem_access_ctrl_if.sv
// Data-memory channel between the MEM stage sequencer and memory.
// Request is valid/ready; load data returns later on d_valid.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    d_req;
  logic                    d_we;
  logic [ADDRESS_BITS-1:0] d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic                    d_ready;
  logic                    d_valid;
  logic [DATA_WIDTH-1:0]   d_rdata;

  modport master (
    output d_req, d_we, d_addr, d_wdata,
    input  d_ready, d_valid, d_rdata
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata,
    output d_ready, d_valid, d_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM stage sequencer: turns EX/MEM load/store controls into a
// data-memory transaction, stalls upstream, and registers writeback.
module mem_access_ctrl #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int TIMEOUT_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_load,
  input  logic                  mem_store,
  input  logic                  mem_regWrite,
  input  logic [DATA_WIDTH-1:0] mem_ALU_result,
  input  logic [DATA_WIDTH-1:0] mem_store_data,
  input  logic [4:0]            mem_rd,
  output logic                  stall,
  mem_access_ctrl_if.master     dmem,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] fault_addr
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  // counter value that becomes all-ones this cycle
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST =
    {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_we;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [4:0]              r_rd;
  logic [TIMEOUT_BITS-1:0] r_wd;
  logic                    r_wb_valid;
  logic [4:0]              r_wb_rd;
  logic [DATA_WIDTH-1:0]   r_wb_data;
  logic                    r_fault;
  logic [DATA_WIDTH-1:0]   r_fault_addr;

  logic w_mem_op;
  logic w_bad;
  logic w_wd_exp;
  logic w_stall;
  logic w_req;
  logic w_unused_core;

  assign w_unused_core = (CORE != 0);
  assign w_mem_op = mem_load | mem_store;
  assign w_bad    = (mem_load & mem_store) |
                    (mem_ALU_result[1:0] != 2'b00);
  assign w_wd_exp = (r_wd == WD_LAST);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_mem_op && !w_bad) w_next = S_REQ;
      S_REQ: begin
        if (dmem.d_ready) w_next = r_we ? S_DONE : S_WAIT;
        else if (w_wd_exp) w_next = S_DONE;
      end
      S_WAIT: if (dmem.d_valid || w_wd_exp) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    w_req   = 1'b0;
    unique case (r_state)
      S_IDLE: w_stall = w_mem_op & ~w_bad;
      S_REQ: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
      end
      S_WAIT: w_stall = 1'b1;
      S_DONE: w_stall = 1'b0;
      default: w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd         <= '0;
      r_wd         <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_fault    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          unique case (1'b1)
            w_mem_op && w_bad: begin
              r_fault      <= 1'b1;
              r_fault_addr <= mem_ALU_result;
            end
            w_mem_op && !w_bad: begin
              r_we    <= mem_store;
              r_addr  <= mem_ALU_result[ADDRESS_BITS-1:0];
              r_wdata <= mem_store_data;
              r_rd    <= mem_rd;
              r_wd    <= '0;
            end
            default: begin
              r_wb_valid <= mem_regWrite & (mem_rd != 5'd0);
              r_wb_rd    <= mem_rd;
              r_wb_data  <= mem_ALU_result;
            end
          endcase
        end
        S_REQ: begin
          r_wd <= r_wd + 1'b1;
          if (!dmem.d_ready && w_wd_exp) begin
            r_fault      <= 1'b1;
            r_fault_addr <= DATA_WIDTH'(r_addr);
          end
        end
        S_WAIT: begin
          r_wd <= r_wd + 1'b1;
          if (dmem.d_valid) begin
            r_wb_valid <= (r_rd != 5'd0);
            r_wb_rd    <= r_rd;
            r_wb_data  <= dmem.d_rdata;
          end else if (w_wd_exp) begin
            r_fault      <= 1'b1;
            r_fault_addr <= DATA_WIDTH'(r_addr);
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

  assign stall        = w_stall;
  assign dmem.d_req   = w_req;
  assign dmem.d_we    = r_we;
  assign dmem.d_addr  = r_addr;
  assign dmem.d_wdata = r_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign fault        = r_fault;
  assign fault_addr   = r_fault_addr;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: scenario tasks plus a writeback/fault
// scoreboard popped by a monitor on the falling edge.
module tb_mem_access_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        mem_load;
  logic        mem_store;
  logic        mem_regWrite;
  logic [31:0] mem_ALU_result;
  logic [31:0] mem_store_data;
  logic [4:0]  mem_rd;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;
  logic [31:0] fault_addr;

  int total = 0;
  int bad   = 0;

  logic [36:0] wb_q[$];
  logic [31:0] fault_q[$];

  mem_access_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) dmem ();

  mem_access_ctrl #(
    .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .TIMEOUT_BITS(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mem_load(mem_load),
    .mem_store(mem_store),
    .mem_regWrite(mem_regWrite),
    .mem_ALU_result(mem_ALU_result),
    .mem_store_data(mem_store_data),
    .mem_rd(mem_rd),
    .stall(stall),
    .dmem(dmem),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .fault(fault),
    .fault_addr(fault_addr)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      if (wb_valid) begin
        total++;
        if (wb_q.size() == 0) begin
          bad++;
          $display("FAIL wb_unexpected: got rd=%0d data=%h want none",
                   wb_rd, wb_data);
        end else begin
          logic [36:0] e;
          e = wb_q.pop_front();
          if ({wb_rd, wb_data} !== e) begin
            bad++;
            $display("FAIL wb_match: got rd=%0d data=%h want rd=%0d data=%h",
                     wb_rd, wb_data, e[36:32], e[31:0]);
          end
        end
      end
      if (fault) begin
        total++;
        if (fault_q.size() == 0) begin
          bad++;
          $display("FAIL fault_unexpected: got addr=%h want none", fault_addr);
        end else begin
          logic [31:0] f;
          f = fault_q.pop_front();
          if (fault_addr !== f) begin
            bad++;
            $display("FAIL fault_addr: got %h want %h", fault_addr, f);
          end
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic mem_in(input logic ld, input logic st, input logic rw,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] sd);
    mem_load       = ld;
    mem_store      = st;
    mem_regWrite   = rw;
    mem_rd         = rd;
    mem_ALU_result = alu;
    mem_store_data = sd;
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] data);
    drive_edge();
    mem_in(1, 0, 1, rd, addr, 0);
    dmem.d_ready = 1'b1;
    dmem.d_valid = 1'b0;
    sample();
    drive_edge();
    sample();
    drive_edge();
    dmem.d_ready = 1'b0;
    dmem.d_valid = 1'b1;
    dmem.d_rdata = data;
    if (rd != 5'd0) wb_q.push_back({rd, data});
    sample();
    drive_edge();
    dmem.d_valid = 1'b0;
    sample();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_in(0, 0, 0, 0, 0, 0);
    dmem.d_ready = 1'b0;
    dmem.d_valid = 1'b0;
    dmem.d_rdata = '0;
    repeat (2) @(posedge clock);
    sample();
    total++;
    if ({stall, dmem.d_req, dmem.d_we, dmem.d_addr, dmem.d_wdata,
         wb_valid, wb_rd, wb_data, fault, fault_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got stall=%b req=%b wbv=%b fault=%b want all 0",
               stall, dmem.d_req, wb_valid, fault);
    end
    drive_edge();
    reset = 1'b0;
    sample();
  endtask

  task automatic test_nonmem();
    drive_edge();
    mem_in(0, 0, 1, 5, 32'h1234, 0);
    wb_q.push_back({5'd5, 32'h1234});
    sample();
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL nonmem_stall0: got %b want 0", stall);
    end
    drive_edge();
    mem_in(0, 0, 1, 0, 32'h9999, 0);
    sample();
    total++;
    if ({stall, wb_valid, wb_rd, wb_data} !== {1'b0, 1'b1, 5'd5, 32'h1234}) begin
      bad++;
      $display("FAIL nonmem_wb: got stall=%b wbv=%b rd=%0d data=%h want 0 1 5 00001234",
               stall, wb_valid, wb_rd, wb_data);
    end
    drive_edge();
    mem_in(0, 0, 0, 0, 0, 0);
    sample();
    total++;
    if (wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL nonmem_rd0: got wbv=%b want 0", wb_valid);
    end
  endtask

  task automatic test_load();
    logic [3:0] stalls;
    stalls = '0;
    drive_edge();
    mem_in(1, 0, 1, 7, 32'h100, 0);
    dmem.d_ready = 1'b1;
    sample();
    stalls[0] = stall;
    total++;
    if (dmem.d_req !== 1'b0) begin
      bad++;
      $display("FAIL load_c0_req: got %b want 0", dmem.d_req);
    end
    drive_edge();
    sample();
    stalls[1] = stall;
    total++;
    if ({dmem.d_req, dmem.d_we, dmem.d_addr} !== {1'b1, 1'b0, 20'h00100}) begin
      bad++;
      $display("FAIL load_req: got req=%b we=%b addr=%h want 1 0 00100",
               dmem.d_req, dmem.d_we, dmem.d_addr);
    end
    drive_edge();
    dmem.d_ready = 1'b0;
    dmem.d_valid = 1'b1;
    dmem.d_rdata = 32'hCAFEF00D;
    wb_q.push_back({5'd7, 32'hCAFEF00D});
    sample();
    stalls[2] = stall;
    drive_edge();
    dmem.d_valid = 1'b0;
    sample();
    stalls[3] = stall;
    total++;
    if (stalls !== 4'b0111) begin
      bad++;
      $display("FAIL load_stall_pattern: got %b want 0111 (c3..c0)", stalls);
    end
    total++;
    if ({wb_valid, wb_data} !== {1'b1, 32'hCAFEF00D}) begin
      bad++;
      $display("FAIL load_wb_c3: got wbv=%b data=%h want 1 cafef00d",
               wb_valid, wb_data);
    end
  endtask

  task automatic test_store_wait();
    drive_edge();
    mem_in(0, 1, 0, 0, 32'h2000, 32'hA5A5A5A5);
    dmem.d_ready = 1'b0;
    sample();
    total++;
    if ({stall, dmem.d_req} !== 2'b10) begin
      bad++;
      $display("FAIL store_c0: got stall=%b req=%b want 1 0", stall, dmem.d_req);
    end
    for (int i = 0; i < 4; i++) begin
      drive_edge();
      dmem.d_ready = (i == 3);
      sample();
      total++;
      if ({stall, dmem.d_req, dmem.d_we, dmem.d_addr, dmem.d_wdata} !==
          {1'b1, 1'b1, 1'b1, 20'h02000, 32'hA5A5A5A5}) begin
        bad++;
        $display("FAIL store_hold_%0d: got req=%b we=%b addr=%h wdata=%h want 1 1 02000 a5a5a5a5",
                 i, dmem.d_req, dmem.d_we, dmem.d_addr, dmem.d_wdata);
      end
    end
    drive_edge();
    dmem.d_ready = 1'b0;
    sample();
    total++;
    if ({stall, dmem.d_req, wb_valid} !== 3'b000) begin
      bad++;
      $display("FAIL store_done: got stall=%b req=%b wbv=%b want 0 0 0",
               stall, dmem.d_req, wb_valid);
    end
  endtask

  task automatic test_fault();
    drive_edge();
    mem_in(1, 0, 1, 3, 32'h102, 0);
    fault_q.push_back(32'h102);
    sample();
    total++;
    if ({stall, dmem.d_req} !== 2'b00) begin
      bad++;
      $display("FAIL misalign_c0: got stall=%b req=%b want 0 0", stall, dmem.d_req);
    end
    drive_edge();
    mem_in(1, 1, 1, 4, 32'h300, 32'h1);
    fault_q.push_back(32'h300);
    sample();
    total++;
    if ({stall, dmem.d_req, fault, fault_addr} !== {3'b001, 32'h102}) begin
      bad++;
      $display("FAIL misalign_pulse: got stall=%b req=%b fault=%b addr=%h want 0 0 1 00000102",
               stall, dmem.d_req, fault, fault_addr);
    end
    drive_edge();
    mem_in(0, 0, 0, 0, 0, 0);
    sample();
    total++;
    if ({stall, dmem.d_req, fault, fault_addr, wb_valid} !== {3'b001, 32'h300, 1'b0}) begin
      bad++;
      $display("FAIL ldst_pulse: got stall=%b req=%b fault=%b addr=%h wbv=%b want 0 0 1 00000300 0",
               stall, dmem.d_req, fault, fault_addr, wb_valid);
    end
    drive_edge();
    sample();
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL fault_single: got %b want 0", fault);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit done;
    n = 0;
    done = 0;
    fault_q.push_back(32'h400);
    for (int i = 0; i < 400 && !done; i++) begin
      drive_edge();
      if (i == 0) mem_in(1, 0, 1, 9, 32'h400, 0);
      dmem.d_ready = (i < 2);
      sample();
      if (stall) n++;
      else done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout_expire: got stall stuck want release within 400");
    end
    total++;
    if (n != 256) begin
      bad++;
      $display("FAIL timeout_len: got %0d stall cycles want 256", n);
    end
    total++;
    if ({fault, wb_valid, dmem.d_req} !== 3'b100) begin
      bad++;
      $display("FAIL timeout_pulse: got fault=%b wbv=%b req=%b want 1 0 0",
               fault, wb_valid, dmem.d_req);
    end
    run_load(32'h404, 5'd10, 32'h55AA1234);
  endtask

  task automatic test_back_to_back();
    run_load(32'h10, 5'd1, 32'h11111111);
    run_load(32'h14, 5'd0, 32'h22222222);
    run_load(32'h18, 5'd31, 32'h33333333);
    drive_edge();
    mem_in(0, 0, 1, 12, 32'hABCD0000, 0);
    wb_q.push_back({5'd12, 32'hABCD0000});
    sample();
    drive_edge();
    mem_in(0, 0, 0, 0, 0, 0);
    sample();
    total++;
    if ({wb_valid, wb_rd} !== {1'b1, 5'd12}) begin
      bad++;
      $display("FAIL b2b_nonmem: got wbv=%b rd=%0d want 1 12", wb_valid, wb_rd);
    end
  endtask

  task automatic test_reset_wait();
    drive_edge();
    mem_in(1, 0, 1, 11, 32'h500, 0);
    dmem.d_ready = 1'b1;
    sample();
    drive_edge();
    sample();
    drive_edge();
    dmem.d_ready = 1'b0;
    reset = 1'b1;
    mem_in(0, 0, 0, 0, 0, 0);
    sample();
    total++;
    if ({stall, dmem.d_req} !== 2'b10) begin
      bad++;
      $display("FAIL rstwait_in_wait: got stall=%b req=%b want 1 0", stall, dmem.d_req);
    end
    drive_edge();
    reset = 1'b0;
    dmem.d_valid = 1'b1;
    dmem.d_rdata = 32'hDEAD0000;
    sample();
    total++;
    if ({stall, dmem.d_req, dmem.d_we, dmem.d_addr, dmem.d_wdata,
         wb_valid, wb_rd, wb_data, fault, fault_addr} !== '0) begin
      bad++;
      $display("FAIL rstwait_outputs: got stall=%b req=%b addr=%h wbd=%h wbv=%b want all 0",
               stall, dmem.d_req, dmem.d_addr, wb_data, wb_valid);
    end
    drive_edge();
    dmem.d_valid = 1'b0;
    sample();
    total++;
    if ({wb_valid, stall} !== 2'b00) begin
      bad++;
      $display("FAIL rstwait_late_valid: got wbv=%b stall=%b want 0 0", wb_valid, stall);
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store_wait();
    test_fault();
    test_timeout();
    test_back_to_back();
    test_reset_wait();
    drive_edge();
    sample();
    total++;
    if (wb_q.size() != 0) begin
      bad++;
      $display("FAIL wb_missing: got %0d pending want 0", wb_q.size());
    end
    total++;
    if (fault_q.size() != 0) begin
      bad++;
      $display("FAIL fault_missing: got %0d pending want 0", fault_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
